// File: rtl/arm_pkg.sv
// Shared ARM core types: field widths and the ID/EX control bundle.
package arm_pkg;

  localparam int EXE_CMD_W  = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;
  localparam int REG_IDX_W  = 4;

  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 b;
    logic                 s;
    logic [EXE_CMD_W-1:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic                  imm;
    logic [SHIFT_OP_W-1:0] shift_operand;
    logic [IMM24_W-1:0]    signed_imm24;
    logic [REG_IDX_W-1:0]  dest;
    logic [REG_IDX_W-1:0]  src1;
    logic [REG_IDX_W-1:0]  src2;
    logic                  carry;
  } fields_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bus: decoded inputs, registered outputs, counters.
interface id_ex_stage_reg_if
  import arm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);

  logic                  freeze;
  logic                  flush;

  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  b_in;
  logic                  s_in;
  logic [EXE_CMD_W-1:0]  exe_cmd_in;
  logic [DW-1:0]         pc_in;
  logic [DW-1:0]         val_rn_in;
  logic [DW-1:0]         val_rm_in;
  logic                  imm_in;
  logic [SHIFT_OP_W-1:0] shift_operand_in;
  logic [IMM24_W-1:0]    signed_imm24_in;
  logic [REG_IDX_W-1:0]  dest_in;
  logic [REG_IDX_W-1:0]  src1_in;
  logic [REG_IDX_W-1:0]  src2_in;
  logic                  carry_in;

  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic                  b_out;
  logic                  s_out;
  logic [EXE_CMD_W-1:0]  exe_cmd_out;
  logic [DW-1:0]         pc_out;
  logic [DW-1:0]         val_rn_out;
  logic [DW-1:0]         val_rm_out;
  logic                  imm_out;
  logic [SHIFT_OP_W-1:0] shift_operand_out;
  logic [IMM24_W-1:0]    signed_imm24_out;
  logic [REG_IDX_W-1:0]  dest_out;
  logic [REG_IDX_W-1:0]  src1_out;
  logic [REG_IDX_W-1:0]  src2_out;
  logic                  carry_out;

  logic                  valid_out;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output freeze, flush,
    output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in,
    output exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in,
    output shift_operand_in, signed_imm24_in,
    output dest_in, src1_in, src2_in, carry_in,
    input  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
    input  exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
    input  shift_operand_out, signed_imm24_out,
    input  dest_out, src1_out, src2_out, carry_out,
    input  valid_out, stall_cnt, flush_cnt
  );

  modport slave (
    input  freeze, flush,
    input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in,
    input  exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in,
    input  shift_operand_in, signed_imm24_in,
    input  dest_in, src1_in, src2_in, carry_in,
    output wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
    output exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
    output shift_operand_out, signed_imm24_out,
    output dest_out, src1_out, src2_out, carry_out,
    output valid_out, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and event counters.
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_reg_if.slave bus
);

  ctrl_t         ctrl_d, ctrl_q;
  fields_t       fld_d, fld_q;
  logic [DW-1:0] pc_q, rn_q, rm_q;
  logic          valid_q;

  assign ctrl_d = '{
    wb_en:    bus.wb_en_in,
    mem_r_en: bus.mem_r_en_in,
    mem_w_en: bus.mem_w_en_in,
    b:        bus.b_in,
    s:        bus.s_in,
    exe_cmd:  bus.exe_cmd_in
  };

  assign fld_d = '{
    imm:           bus.imm_in,
    shift_operand: bus.shift_operand_in,
    signed_imm24:  bus.signed_imm24_in,
    dest:          bus.dest_in,
    src1:          bus.src1_in,
    src2:          bus.src2_in,
    carry:         bus.carry_in
  };

  // Flush beats freeze so a taken branch can kill a stalled entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= BUBBLE;
      fld_q   <= '0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      ctrl_q  <= BUBBLE;
      fld_q   <= '0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      valid_q <= 1'b0;
    end else if (!bus.freeze) begin
      ctrl_q  <= ctrl_d;
      fld_q   <= fld_d;
      pc_q    <= bus.pc_in;
      rn_q    <= bus.val_rn_in;
      rm_q    <= bus.val_rm_in;
      valid_q <= 1'b1;
    end
  end

  assign bus.wb_en_out         = ctrl_q.wb_en;
  assign bus.mem_r_en_out      = ctrl_q.mem_r_en;
  assign bus.mem_w_en_out      = ctrl_q.mem_w_en;
  assign bus.b_out             = ctrl_q.b;
  assign bus.s_out             = ctrl_q.s;
  assign bus.exe_cmd_out       = ctrl_q.exe_cmd;
  assign bus.pc_out            = pc_q;
  assign bus.val_rn_out        = rn_q;
  assign bus.val_rm_out        = rm_q;
  assign bus.imm_out           = fld_q.imm;
  assign bus.shift_operand_out = fld_q.shift_operand;
  assign bus.signed_imm24_out  = fld_q.signed_imm24;
  assign bus.dest_out          = fld_q.dest;
  assign bus.src1_out          = fld_q.src1;
  assign bus.src2_out          = fld_q.src2;
  assign bus.carry_out         = fld_q.carry;
  assign bus.valid_out         = valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.freeze & ~bus.flush),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.flush),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: entry-level model plus directed literals.
module tb_id_ex_stage_reg;
  import arm_pkg::*;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] off;
    logic [3:0]  dest, s1, s2;
    logic        c;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t drv = '0;
  ent_t act;
  ent_t exp_e = '0;
  logic exp_valid = 1'b0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b1;

  assign bus.freeze           = freeze;
  assign bus.flush            = flush;
  assign bus.wb_en_in         = drv.wb;
  assign bus.mem_r_en_in      = drv.mr;
  assign bus.mem_w_en_in      = drv.mw;
  assign bus.b_in             = drv.b;
  assign bus.s_in             = drv.s;
  assign bus.exe_cmd_in       = drv.cmd;
  assign bus.pc_in            = drv.pc;
  assign bus.val_rn_in        = drv.rn;
  assign bus.val_rm_in        = drv.rm;
  assign bus.imm_in           = drv.imm;
  assign bus.shift_operand_in = drv.sh;
  assign bus.signed_imm24_in  = drv.off;
  assign bus.dest_in          = drv.dest;
  assign bus.src1_in          = drv.s1;
  assign bus.src2_in          = drv.s2;
  assign bus.carry_in         = drv.c;

  assign act = '{
    wb: bus.wb_en_out, mr: bus.mem_r_en_out,
    mw: bus.mem_w_en_out, b: bus.b_out, s: bus.s_out,
    cmd: bus.exe_cmd_out, pc: bus.pc_out,
    rn: bus.val_rn_out, rm: bus.val_rm_out,
    imm: bus.imm_out, sh: bus.shift_operand_out,
    off: bus.signed_imm24_out, dest: bus.dest_out,
    s1: bus.src1_out, s2: bus.src2_out, c: bus.carry_out
  };

  task automatic check(string name, logic [199:0] a, logic [199:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  // Model: one stored entry, a bubble is the all-zero entry.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_e = '0;
      exp_valid = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
    end else if (flush) begin
      exp_e = '0;
      exp_valid = 1'b0;
      exp_flush = (exp_flush < CMAX) ? exp_flush + 1 : CMAX;
    end else if (freeze) begin
      exp_stall = (exp_stall < CMAX) ? exp_stall + 1 : CMAX;
    end else begin
      exp_e = drv;
      exp_valid = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("entry", act, exp_e);
      check("valid", bus.valid_out, exp_valid);
      check("stall_cnt", bus.stall_cnt, exp_stall[CNT_W-1:0]);
      check("flush_cnt", bus.flush_cnt, exp_flush[CNT_W-1:0]);
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12 rst = 1'b0;
    step();

    drv.pc = 32'h40;
    drv.wb = 1'b1;
    step();
    check("pre_rst_pc", bus.pc_out, 32'h40);
    freeze = 1'b1;
    step(2);
    freeze = 1'b0;
    check("pre_rst_stall", bus.stall_cnt, 4'd2);

    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.pc_out, 32'h0);
    check("async_rst_wb", bus.wb_en_out, 1'b0);
    check("async_rst_valid", bus.valid_out, 1'b0);
    check("async_rst_stall", bus.stall_cnt, 4'd0);
    step();
    check("rst_hold_pc", bus.pc_out, 32'h0);
    rst = 1'b0;

    drv = '0;
    drv.rn = 32'h5;
    drv.rm = 32'hA;
    drv.cmd = 4'b0010;
    drv.dest = 4'd3;
    drv.wb = 1'b1;
    drv.pc = 32'h44;
    step();
    check("load_rn", bus.val_rn_out, 32'h5);
    check("load_rm", bus.val_rm_out, 32'hA);
    check("load_cmd", bus.exe_cmd_out, 4'b0010);
    check("load_dest", bus.dest_out, 4'd3);
    check("load_valid", bus.valid_out, 1'b1);

    freeze = 1'b1;
    drv.pc = 32'h80;
    step(3);
    check("freeze_pc", bus.pc_out, 32'h44);
    check("freeze_stall", bus.stall_cnt, 4'd3);

    freeze = 1'b0;
    drv.pc = 32'h90;
    drv.s = 1'b1;
    drv.c = 1'b1;
    step();
    flush = 1'b1;
    freeze = 1'b1;
    step();
    check("flush_wb", bus.wb_en_out, 1'b0);
    check("flush_s", bus.s_out, 1'b0);
    check("flush_pc", bus.pc_out, 32'h0);
    check("flush_valid", bus.valid_out, 1'b0);
    check("flush_cnt1", bus.flush_cnt, 4'd1);
    check("flush_stall", bus.stall_cnt, 4'd3);

    flush = 1'b0;
    step(20);
    check("stall_sat", bus.stall_cnt, 4'd15);
    freeze = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      drv.pc = 32'(4 * i);
      drv.rn = $urandom;
      drv.rm = $urandom;
      drv.sh = 12'($urandom);
      drv.off = 24'($urandom);
      drv.cmd = 4'($urandom);
      drv.s1 = 4'(i);
      drv.s2 = 4'(15 - i);
      drv.mr = i[0];
      drv.mw = i[1];
      drv.b = i[2];
      drv.imm = ~i[0];
      step();
      check("b2b_pc", bus.pc_out, 32'(4 * i));
      check("b2b_valid", bus.valid_out, 1'b1);
    end

    flush = 1'b1;
    step(17);
    check("flush_sat", bus.flush_cnt, 4'd15);
    flush = 1'b0;
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
